// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake.
// Emits one bit per clock, supports gap-free back-to-back words and a stall input.
module piso_shift_register #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast    = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntPreLast = CntW'(WIDTH - 2);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             done_q, done_d;

  logic             last_bit;
  logic             load_fire;

  // First bit to present from a word, honouring the bit order.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with the presented bit removed; vacated positions fill with 0.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready when idle, or when the last bit is leaving this cycle (gap-free reload).
  always_comb begin
    last_bit   = (state_q == StShift) && (cnt_q == CntLast);
    load_ready = (state_q == StIdle) || (last_bit && shift_en);
    load_fire  = load_valid && load_ready;
  end

  // Next-state logic: load takes priority, otherwise shift or retire the word.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    sout_d        = sout_q;
    sout_valid_d  = sout_valid_q;
    frame_start_d = frame_start_q;
    done_d        = done_q;

    if (load_fire) begin
      state_d       = StShift;
      cnt_d         = '0;
      sout_d        = first_bit(load_data);
      shreg_d       = shift_out(load_data);
      sout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
      done_d        = 1'b0;
    end else if ((state_q == StShift) && shift_en) begin
      if (last_bit) begin
        state_d       = StIdle;
        cnt_d         = '0;
        shreg_d       = '0;
        sout_d        = 1'b0;
        sout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
      end else begin
        cnt_d         = cnt_q + CntW'(1);
        sout_d        = first_bit(shreg_q);
        shreg_d       = shift_out(shreg_q);
        frame_start_d = 1'b0;
        done_d        = (cnt_q == CntPreLast);
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      cnt_q         <= '0;
      sout_q        <= 1'b0;
      sout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      sout_q        <= sout_d;
      sout_valid_q  <= sout_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
    end
  end

  assign sout        = sout_q;
  assign sout_valid  = sout_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed, table-driven bench for piso_shift_register. Two instances share the
// stimulus: one sends MSB first, the other LSB first.
module tb_piso_shift_register;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [7:0] load_data;
  logic       shift_en;

  logic lr_m, sout_m, sv_m, fs_m, dn_m;
  logic lr_l, sout_l, sv_l, fs_l, dn_l;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       lv;
    logic [7:0] data;
    logic       se;
    logic       sm;   // expected sout, MSB-first instance
    logic       sl;   // expected sout, LSB-first instance
    logic       sv;
    logic       fs;
    logic       dn;
    logic       lr;
  } vec_t;

  vec_t vecs[$];

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (lr_m),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .sout       (sout_m),
    .sout_valid (sv_m),
    .frame_start(fs_m),
    .done       (dn_m)
  );

  piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (lr_l),
    .load_data  (load_data),
    .shift_en   (shift_en),
    .sout       (sout_l),
    .sout_valid (sv_l),
    .frame_start(fs_l),
    .done       (dn_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%b want=%b", name, idx, act, exp);
    end
  endtask

  task automatic chk4(input string name, input int idx, input logic [3:0] act,
                      input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%b want=%b", name, idx, act, exp);
    end
  endtask

  task automatic push(input logic lv, input logic [7:0] d, input logic se, input logic sm,
                      input logic sl, input logic sv, input logic fs, input logic dn,
                      input logic lr);
    vec_t v;
    v.lv = lv; v.data = d; v.se = se; v.sm = sm; v.sl = sl;
    v.sv = sv; v.fs = fs; v.dn = dn; v.lr = lr;
    vecs.push_back(v);
  endtask

  // Idle-state expectation row with the given inputs.
  task automatic push_idle(input logic lv, input logic [7:0] d, input logic se);
    push(lv, d, se, L, L, L, L, L, H);
  endtask

  // One plain word: load in IDLE, 8 bits with shift_en=1, then one idle row.
  task automatic push_word(input logic [7:0] d, input logic [7:0] seq_m,
                           input logic [7:0] seq_l);
    push_idle(H, d, H);
    for (int i = 1; i <= 8; i++) begin
      push(L, 8'h00, H, seq_m[8-i], seq_l[8-i], H, (i == 1), (i == 8), (i == 8));
    end
    push_idle(L, 8'h00, H);
  endtask

  // Inputs are applied just after a rising edge; outputs are sampled on the falling edge.
  task automatic run_table();
    int k;
    k = 0;
    foreach (vecs[n]) begin
      load_valid = vecs[n].lv;
      load_data  = vecs[n].data;
      shift_en   = vecs[n].se;
      @(negedge clk);
      chk1("sout_msb", n, sout_m, vecs[n].sm);
      chk1("sout_lsb", n, sout_l, vecs[n].sl);
      chk1("sout_valid", n, sv_m, vecs[n].sv);
      chk1("frame_start", n, fs_m, vecs[n].fs);
      chk1("done", n, dn_m, vecs[n].dn);
      chk1("load_ready", n, lr_m, vecs[n].lr);
      chk4("lsb_ctrl", n, {sv_l, fs_l, dn_l, lr_l},
           {vecs[n].sv, vecs[n].fs, vecs[n].dn, vecs[n].lr});
      @(posedge clk);
      #1;
      k++;
    end
    vecs.delete();
  endtask

  logic [7:0]  seq_m;
  logic [7:0]  seq_l;
  logic [15:0] seq16;

  initial begin
    // Reset held with load_valid asserted: nothing may load.
    rst_n      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    shift_en   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk4("rst_out_msb", 0, {sout_m, sv_m, fs_m, dn_m}, 4'b0000);
    chk4("rst_out_lsb", 0, {sout_l, sv_l, fs_l, dn_l}, 4'b0000);
    rst_n = 1'b1;
    #1;
    chk1("rst_release_ready_msb", 0, lr_m, H);
    chk1("rst_release_ready_lsb", 0, lr_l, H);
    load_valid = 1'b0;
    @(posedge clk);
    #1;

    // 0xA5 with ignored offers while busy (cycles 2..4).
    seq_m = 8'b1010_0101;
    seq_l = 8'b1010_0101;
    push_idle(H, 8'hA5, H);
    for (int i = 1; i <= 8; i++) begin
      push((i >= 2 && i <= 4), 8'h00, H, seq_m[8-i], seq_l[8-i], H, (i == 1), (i == 8),
           (i == 8));
    end
    push_idle(L, 8'h00, H);

    // Back-to-back 0xA5 then 0x3C, second word offered in cycle 8.
    seq16 = 16'b1010_0101_0011_1100;
    push_idle(H, 8'hA5, H);
    for (int i = 1; i <= 16; i++) begin
      push((i == 8), 8'h3C, H, seq16[16-i], seq16[16-i], H, (i == 1 || i == 9),
           (i == 8 || i == 16), (i == 8 || i == 16));
    end
    push_idle(L, 8'h00, H);

    // 0xFF loaded with shift_en=0 in IDLE; stall in cycles 3..5 and at the last bit.
    push_idle(H, 8'hFF, L);
    for (int i = 1; i <= 10; i++) begin
      push(L, 8'h00, !(i >= 3 && i <= 5), H, H, H, (i == 1), L, L);
    end
    push(H, 8'h00, L, H, H, H, L, H, L);
    push(L, 8'h00, H, H, H, H, L, H, H);
    push_idle(L, 8'h00, H);

    // 0x01 shows the bit order difference between the two instances.
    push_word(8'h01, 8'b0000_0001, 8'b1000_0000);
    run_table();

    // Mid-word asynchronous reset during cycle 4 of 0xFF.
    load_valid = 1'b1;
    load_data  = 8'hFF;
    shift_en   = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk4("pre_rst_msb", 0, {sout_m, sv_m, fs_m, dn_m}, 4'b1100);
    #1;
    rst_n = 1'b0;
    #1;
    chk4("async_rst_msb", 0, {sout_m, sv_m, fs_m, dn_m}, 4'b0000);
    chk4("async_rst_lsb", 0, {sout_l, sv_l, fs_l, dn_l}, 4'b0000);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk1("post_rst_ready", 0, lr_m, H);
    chk1("post_rst_valid", 0, sv_m, L);
    @(posedge clk);
    #1;

    // Fresh word after the abort serializes from its first bit.
    push_word(8'hC1, 8'b1100_0001, 8'b1000_0011);
    run_table();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_shift_register.md
Name: piso_shift_register

Overview:
- Parallel-in, serial-out shift register. It is the transmit end of a serial bit stream: it accepts a WIDTH-bit word through a valid/ready load handshake and emits one bit per clock.
- Sits between word-wide storage logic and any serial-in flip-flop chain or receiver.
- Supports back-to-back words with no idle bit and a stall input that freezes shifting.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- load_valid  input  1  load_data is offered this cycle.
- load_ready  output  1  block accepts a word this cycle (combinational).
- load_data  input  WIDTH  word to serialize; sampled only on handshake.
- shift_en  input  1  1 = advance one bit this cycle; 0 = hold all state.
- sout  output  1  current serial bit (registered).
- sout_valid  output  1  sout carries a valid data bit (registered).
- frame_start  output  1  high during the first bit of each word (registered).
- done  output  1  high during the last bit of each word (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; shift register and bit counter clear to 0.
  - sout, sout_valid, frame_start and done go to 0.
  - load_ready is 1 once reset is released.
- States are IDLE and SHIFT. The bit counter cnt is clog2(WIDTH) bits wide and counts bits already presented.
- Handshake: a word is accepted on a rising edge where load_valid and load_ready are both 1.
- load_ready = (state==IDLE) OR (state==SHIFT AND cnt==WIDTH-1 AND shift_en).
  - It does not depend on load_valid.
- IDLE:
  - sout_valid=0, frame_start=0, done=0, sout=0.
  - On handshake: capture load_data, go to SHIFT, set cnt=0.
  - In the next cycle, sout = first bit (per MSB_FIRST), sout_valid=1 and frame_start=1.
  - Latency is one cycle from the handshake edge to the first bit.
- SHIFT with shift_en=1:
  - At the edge, advance to the next bit and increment cnt.
  - frame_start is 1 only while cnt==0.
  - done is 1 only while cnt==WIDTH-1.
- SHIFT with shift_en=0:
  - sout, sout_valid, frame_start, done, cnt and the shift register all hold.
  - load_ready=0, unless in IDLE.
- Last bit (cnt==WIDTH-1) with shift_en=1:
  - With handshake: load the new word, cnt goes to 0, stay in SHIFT. The next cycle shows the new word's first bit with frame_start=1. There are no gap cycles.
  - Without handshake: go to IDLE and deassert sout_valid next cycle.
- shift_en is ignored in IDLE. A load in IDLE happens regardless of shift_en.
- load_valid while load_ready=0 has no effect. The offered word is not queued.
- Order for WIDTH bits:
  - MSB_FIRST=1: bit WIDTH-1 down to bit 0.
  - MSB_FIRST=0: bit 0 up to bit WIDTH-1.
- WIDTH=2: frame_start and done alternate; both are never high in the same cycle.
- Reset mid-word aborts the word. Remaining bits are discarded and not resumed.
- No X on any output after reset. The shift register's unused fill bits are 0.

Test Plan:
- Reset with load_valid=1 held → all outputs 0, load_ready=1 immediately after rst_n rises; no load occurs while rst_n is low.
- WIDTH=8, MSB_FIRST=1, shift_en=1, load 0xA5 in IDLE:
  - Cycles 1..8 give sout=1,0,1,0,0,1,0,1 with sout_valid=1.
  - frame_start high only in cycle 1; done high only in cycle 8.
  - sout_valid=0 in cycle 9; load_ready=0 in cycles 1..7.
- Back-to-back 0xA5 then 0x3C, second word offered during cycle 8:
  - 16 consecutive valid bits, 1010_0101_0011_1100.
  - frame_start in cycles 1 and 9; done in cycles 8 and 16; no gap.
- Load 0xFF, drop shift_en in cycles 3..5 → sout and cnt hold at bit 2 for 3 extra cycles; done arrives in cycle 11; load_ready stays 0 while stalled at the last bit.
- MSB_FIRST=0, load 0x01 → sout=1 in cycle 1, then 0 in cycles 2..8.
- rst_n pulsed low in cycle 4 of a word → outputs clear asynchronously (mid-cycle); after release, IDLE with load_ready=1; the next word loaded serializes correctly from its first bit.
